// File: rtl/bit_stream_serializer_if.sv
// bit_stream_serializer_if: load handshake and serial output bundle
interface bit_stream_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             busy;
   logic             word_done;
   modport master (
      output data_in, load_valid,
      input  load_ready, ser_out, ser_valid, busy, word_done
   );
   modport slave (
      input  data_in, load_valid,
      output load_ready, ser_out, ser_valid, busy, word_done
   );
endinterface

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel word to one-bit-per-clock stream with valid/ready load
module bit_stream_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   parameter int GAP       = 0,
   parameter int IDLE_BIT  = 0
) (
   input logic clk,
   input logic rst,
   bit_stream_serializer_if.slave s
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] sreg_q;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       gcnt_q;
   logic             ser_out_q, ser_valid_q, busy_q, word_done_q;
   logic             last, xfer, first_bit_d, next_bit_d;
   logic [WIDTH-1:0] load_sreg_d, shift_sreg_d;
   assign last  = cnt_q == CW'(WIDTH - 1);
   assign s.load_ready = (state_q == IDLE) || (GAP == 0 && state_q == SHIFT && last);
   assign xfer  = s.load_valid & s.load_ready;
   // shift reg holds the bits still to go; the outgoing bit is already in ser_out_q
   assign first_bit_d  = (MSB_FIRST != 0) ? s.data_in[WIDTH-1] : s.data_in[0];
   assign load_sreg_d  = (MSB_FIRST != 0) ? s.data_in << 1 : s.data_in >> 1;
   assign next_bit_d   = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
   assign shift_sreg_d = (MSB_FIRST != 0) ? sreg_q << 1 : sreg_q >> 1;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         gcnt_q      <= '0;
         ser_out_q   <= 1'(IDLE_BIT);
         ser_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         word_done_q <= 1'b0;
      end else if (xfer) begin
         state_q     <= SHIFT;
         sreg_q      <= load_sreg_d;
         cnt_q       <= '0;
         ser_out_q   <= first_bit_d;
         ser_valid_q <= 1'b1;
         busy_q      <= 1'b1;
         word_done_q <= 1'b0;
      end else begin
         case (state_q)
            SHIFT: begin
               if (!last) begin
                  ser_out_q   <= next_bit_d;
                  sreg_q      <= shift_sreg_d;
                  cnt_q       <= cnt_q + 1'b1;
                  word_done_q <= cnt_q == CW'(WIDTH - 2);
               end else begin
                  state_q     <= (GAP > 0) ? GAPS : IDLE;
                  gcnt_q      <= '0;
                  ser_out_q   <= 1'(IDLE_BIT);
                  ser_valid_q <= 1'b0;
                  busy_q      <= GAP > 0;
                  word_done_q <= 1'b0;
               end
            end
            GAPS: begin
               if (gcnt_q == 4'(GAP - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gcnt_q  <= gcnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
   assign s.ser_out   = ser_out_q;
   assign s.ser_valid = ser_valid_q;
   assign s.busy      = busy_q;
   assign s.word_done = word_done_q;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb_bit_stream_serializer: vector table, corner sequences and random run against a queue model
module tb_bit_stream_serializer;
   localparam int PW[3] = '{8, 8, 5};
   localparam int PM[3] = '{1, 0, 1};
   localparam int PG[3] = '{0, 2, 3};
   localparam int PI[3] = '{0, 0, 1};
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   bit_stream_serializer_if #(.WIDTH(8)) b0 ();
   bit_stream_serializer_if #(.WIDTH(8)) b1 ();
   bit_stream_serializer_if #(.WIDTH(5)) b2 ();
   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0), .IDLE_BIT(0)) dut0 (.clk(clk), .rst(rst), .s(b0));
   bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(2), .IDLE_BIT(0)) dut1 (.clk(clk), .rst(rst), .s(b1));
   bit_stream_serializer #(.WIDTH(5), .MSB_FIRST(1), .GAP(3), .IDLE_BIT(1)) dut2 (.clk(clk), .rst(rst), .s(b2));
   typedef struct {logic r; logic lv; logic [7:0] d; logic [4:0] e;} vec_t;
   typedef struct {logic v; logic b; logic last;} rec_t;
   vec_t tbl[39];
   rec_t q[$];
   // packed as {ser_out, ser_valid, word_done, busy, load_ready}
   function automatic logic [4:0] outs(int s);
      case (s)
         0: return {b0.ser_out, b0.ser_valid, b0.word_done, b0.busy, b0.load_ready};
         1: return {b1.ser_out, b1.ser_valid, b1.word_done, b1.busy, b1.load_ready};
         default: return {b2.ser_out, b2.ser_valid, b2.word_done, b2.busy, b2.load_ready};
      endcase
   endfunction
   task automatic drive(int s, logic lv, logic [31:0] d);
      b0.load_valid = (s == 0) && lv;
      b1.load_valid = (s == 1) && lv;
      b2.load_valid = (s == 2) && lv;
      b0.data_in = d[7:0];
      b1.data_in = d[7:0];
      b2.data_in = d[4:0];
   endtask
   task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, a, e);
      end
   endtask
   function automatic vec_t mk(logic r, logic lv, logic [7:0] d, logic [4:0] e);
      vec_t v;
      v.r = r; v.lv = lv; v.d = d; v.e = e;
      return v;
   endfunction
   initial begin
      logic [7:0] w, st;
      int c, k;
      tbl = '{
         mk(0,1,8'hB5,5'b11010), mk(0,0,0,5'b01010), mk(0,0,0,5'b11010), mk(0,0,0,5'b11010),
         mk(0,0,0,5'b01010), mk(0,0,0,5'b11010), mk(0,0,0,5'b01010), mk(0,0,0,5'b11111),
         mk(0,0,0,5'b00001),
         mk(0,1,8'hAA,5'b11010), mk(0,1,8'h55,5'b01010), mk(0,1,8'h55,5'b11010), mk(0,1,8'h55,5'b01010),
         mk(0,1,8'h55,5'b11010), mk(0,1,8'h55,5'b01010), mk(0,1,8'h55,5'b11010), mk(0,1,8'h55,5'b01111),
         mk(0,1,8'h55,5'b01010), mk(0,0,0,5'b11010), mk(0,0,0,5'b01010), mk(0,0,0,5'b11010),
         mk(0,0,0,5'b01010), mk(0,0,0,5'b11010), mk(0,0,0,5'b01010), mk(0,0,0,5'b11111),
         mk(0,0,0,5'b00001),
         mk(0,1,8'hB5,5'b11010), mk(0,0,0,5'b01010), mk(0,0,0,5'b11010), mk(1,0,0,5'b00001),
         mk(0,1,8'h0F,5'b01010), mk(0,0,0,5'b01010), mk(0,0,0,5'b01010), mk(0,0,0,5'b01010),
         mk(0,0,0,5'b11010), mk(0,0,0,5'b11010), mk(0,0,0,5'b11010), mk(0,0,0,5'b11111),
         mk(0,0,0,5'b00001)
      };
      drive(0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("reset0", outs(0), 5'b00001);
      chk("reset1", outs(1), 5'b00001);
      chk("reset2", outs(2), 5'b10001);
      rst = 1'b0;
      for (int i = 0; i < 39; i++) begin
         rst = tbl[i].r;
         drive(0, tbl[i].lv, tbl[i].d);
         @(negedge clk);
         chk($sformatf("vec%0d", i), outs(0), tbl[i].e);
      end
      rst = 1'b0;
      drive(0, 1, 8'hAD);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(0, 0, 0);
         st[7-i] = b0.ser_out;
      end
      chk("moore_stream", st, 8'hAD);
      c = 0;
      k = 0;
      while (k <= 5) begin
         if ({st[7-k], st[6-k], st[5-k]} == 3'b101) begin
            c++;
            k += 3;
         end else k++;
      end
      chk("moore_hits", c, 2);
      w = 8'h0D;
      drive(1, 1, w);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(1, 0, 0);
         chk($sformatf("gap_bit%0d", i), outs(1), {w[i], 1'b1, i == 7, 2'b10});
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("gap_idle%0d", i), outs(1), 5'b00010);
      end
      @(negedge clk);
      chk("gap_end", outs(1), 5'b00001);
      drive(1, 1, 8'h00);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(1, 1, 8'hFF);
         chk($sformatf("ign_bit%0d", i), outs(1), {1'b0, 1'b1, i == 7, 2'b10});
      end
      @(negedge clk);
      chk("ign_gap0", outs(1), 5'b00010);
      @(negedge clk);
      chk("ign_gap1", outs(1), 5'b00010);
      drive(1, 0, 0);
      @(negedge clk);
      chk("ign_idle0", outs(1), 5'b00001);
      @(negedge clk);
      chk("ign_idle1", outs(1), 5'b00001);
      drive(1, 1, 8'hFF);
      @(negedge clk);
      drive(1, 0, 0);
      chk("ff_idle", outs(1), 5'b11010);
      for (int s = 0; s < 3; s++) begin
         rst = 1'b1;
         drive(s, 0, 0);
         @(negedge clk);
         q.delete();
         for (int n = 0; n < 500; n++) begin
            logic r, lv, rdy, ib;
            logic [31:0] d;
            logic [4:0] e;
            r  = $urandom_range(0, 99) == 0;
            lv = $urandom_range(0, 3) != 0;
            d  = $urandom;
            rst = r;
            drive(s, lv, d);
            rdy = q.size() == 0 || (PG[s] == 0 && q[0].last);
            if (r) q.delete();
            else begin
               if (q.size() > 0) void'(q.pop_front());
               if (lv && rdy) begin
                  for (int i = 0; i < PW[s]; i++)
                     q.push_back('{1'b1, (PM[s] != 0) ? d[PW[s]-1-i] : d[i], i == PW[s] - 1});
                  for (int i = 0; i < PG[s]; i++) q.push_back('{1'b0, 1'b0, 1'b0});
               end
            end
            @(negedge clk);
            ib = 1'(PI[s]);
            if (q.size() == 0) e = {ib, 4'b0001};
            else e = {q[0].v ? q[0].b : ib, q[0].v, q[0].last, 1'b1, PG[s] == 0 && q[0].last};
            chk($sformatf("rand%0d_%0d", s, n), outs(s), e);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
